// File: rtl/lru_order_array.sv
// Per-set true-LRU recency store: each set keeps a permutation of way IDs, MRU in field 0.
// Reports the LRU victim for a lookup set and applies promote/demote updates; self-initialises after reset.
module lru_order_array #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 32,
  localparam int WAY_W = $clog2(NUM_WAYS),
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int ROW_W = NUM_WAYS * WAY_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_busy,
  input  logic [IDX_W-1:0] lookup_index,
  output logic [WAY_W-1:0] victim_way,
  output logic [ROW_W-1:0] order_out,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             upd_demote
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic logic [ROW_W-1:0] init_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_WAYS; k++) r[k*WAY_W +: WAY_W] = WAY_W'(k);
    return r;
  endfunction

  localparam logic [ROW_W-1:0] INIT_ROW = init_row();
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  // Move way to MRU (promote) or LRU (demote); fields on the far side of it stay put.
  function automatic logic [ROW_W-1:0] reorder(input logic [ROW_W-1:0] row,
                                               input logic [WAY_W-1:0] way,
                                               input logic demote);
    logic [ROW_W-1:0] r;
    int p;
    r = row;
    p = 0;
    for (int k = 0; k < NUM_WAYS; k++)
      if (row[k*WAY_W +: WAY_W] == way) p = k;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (!demote) begin
        if (k == 0) r[k*WAY_W +: WAY_W] = way;
        else if (k <= p) r[k*WAY_W +: WAY_W] = row[(k-1)*WAY_W +: WAY_W];
      end else begin
        if (k == NUM_WAYS - 1) r[k*WAY_W +: WAY_W] = way;
        else if (k >= p) r[k*WAY_W +: WAY_W] = row[(k+1)*WAY_W +: WAY_W];
      end
    end
    return r;
  endfunction

  state_t           state;
  logic [IDX_W-1:0] init_cnt;
  logic [ROW_W-1:0] mem [NUM_SETS];
  logic             we;
  logic [IDX_W-1:0] wr_idx;
  logic [ROW_W-1:0] wr_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + IDX_W'(1);
      if (init_cnt == LAST_SET) state <= ST_READY;
    end
  end

  // The init sweep owns the write port; updates only land once READY, and reset blocks both.
  always_comb begin
    we     = 1'b0;
    wr_idx = init_cnt;
    wr_row = INIT_ROW;
    if (!reset) begin
      if (state == ST_INIT) begin
        we = 1'b1;
      end else if (upd_valid) begin
        we     = 1'b1;
        wr_idx = upd_index;
        wr_row = reorder(mem[upd_index], upd_way, upd_demote);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_row;
  end

  assign init_busy  = (state == ST_INIT);
  assign order_out  = init_busy ? '0 : mem[lookup_index];
  assign victim_way = order_out[(NUM_WAYS-1)*WAY_W +: WAY_W];

endmodule

// File: tb/tb_lru_order_array.sv
// Bench for lru_order_array: directed checks on a 4-way/32-set instance and a
// randomized promote/demote stream on an 8-way/64-set instance against a queue model.
module tb_lru_order_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-way / 32-set instance
  logic       reset_a = 1'b0;
  logic       busy_a;
  logic [4:0] lookup_a = '0;
  logic [1:0] victim_a;
  logic [7:0] order_a;
  logic       uv_a = 1'b0;
  logic [4:0] ui_a = '0;
  logic [1:0] uw_a = '0;
  logic       ud_a = 1'b0;

  lru_order_array #(.NUM_WAYS(4), .NUM_SETS(32)) u_dut_a (
    .clk(clk), .reset(reset_a), .init_busy(busy_a),
    .lookup_index(lookup_a), .victim_way(victim_a), .order_out(order_a),
    .upd_valid(uv_a), .upd_index(ui_a), .upd_way(uw_a), .upd_demote(ud_a)
  );

  // 8-way / 64-set instance
  logic        reset_b = 1'b0;
  logic        busy_b;
  logic [5:0]  lookup_b = '0;
  logic [2:0]  victim_b;
  logic [23:0] order_b;
  logic        uv_b = 1'b0;
  logic [5:0]  ui_b = '0;
  logic [2:0]  uw_b = '0;
  logic        ud_b = 1'b0;

  lru_order_array #(.NUM_WAYS(8), .NUM_SETS(64)) u_dut_b (
    .clk(clk), .reset(reset_b), .init_busy(busy_b),
    .lookup_index(lookup_b), .victim_way(victim_b), .order_out(order_b),
    .upd_valid(uv_b), .upd_index(ui_b), .upd_way(uw_b), .upd_demote(ud_b)
  );

  int model [64][8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference update: pull the way out of the recency list and reinsert it at the front or back.
  task automatic model_upd(input int s, input int w, input bit dem);
    int q[$];
    int idx;
    idx = 0;
    for (int k = 0; k < 8; k++) q.push_back(model[s][k]);
    for (int k = 0; k < 8; k++) if (q[k] == w) idx = k;
    q.delete(idx);
    if (dem) q.push_back(w);
    else q.push_front(w);
    for (int k = 0; k < 8; k++) model[s][k] = q[k];
  endtask

  function automatic logic [23:0] model_row(input int s);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(model[s][k]);
    return r;
  endfunction

  function automatic logic [7:0] way_mask(input logic [23:0] row);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) m[row[k*3 +: 3]] = 1'b1;
    return m;
  endfunction

  task automatic reset_pulse_a();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
  endtask

  task automatic wait_init_a(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 200) begin
      if (n == 0) check_val({tag, "_busy_order"}, 32'(order_a), 32'h0);
      n++;
      tick();
    end
    check_val({tag, "_len"}, n, 32);
  endtask

  task automatic upd_a(input int s, input int w, input bit dem);
    uv_a = 1'b1; ui_a = 5'(s); uw_a = 2'(w); ud_a = dem;
    tick();
    uv_a = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset and init sweep
    reset_pulse_a();
    check_val("busy_after_reset", 32'(busy_a), 32'h1);
    wait_init_a("init1");
    lookup_a = 5'd5; #1;
    check_val("t1_order", 32'(order_a), 32'hE4);
    check_val("t1_victim", 32'(victim_a), 32'h3);

    // Test 2: promote set 5 way 3
    upd_a(5, 3, 1'b0);
    check_val("t2_order", 32'(order_a), 32'h93);
    check_val("t2_victim", 32'(victim_a), 32'h2);
    lookup_a = 5'd6; #1;
    check_val("t2_set6", 32'(order_a), 32'hE4);
    lookup_a = 5'd5; #1;

    // Test 3: promote way 1, demote way 3, promote MRU way 1
    upd_a(5, 1, 1'b0);
    check_val("t3_prom1", 32'(order_a), 32'h8D);
    upd_a(5, 3, 1'b1);
    check_val("t3_dem3", 32'(order_a), 32'hE1);
    check_val("t3_victim", 32'(victim_a), 32'h3);
    upd_a(5, 1, 1'b0);
    check_val("t3_mru_noop", 32'(order_a), 32'hE1);

    // Test 4: same-cycle read and update sees the old order
    uv_a = 1'b1; ui_a = 5'd5; uw_a = 2'd2; ud_a = 1'b0;
    #1;
    check_val("t4_rbw_victim", 32'(victim_a), 32'h3);
    check_val("t4_rbw_order", 32'(order_a), 32'hE1);
    tick();
    uv_a = 1'b0; #1;
    check_val("t4_order", 32'(order_a), 32'hC6);
    check_val("t4_victim", 32'(victim_a), 32'h3);

    // Test 5: update during init ignored; reset mid-sweep restarts
    reset_pulse_a();
    for (int i = 0; i < 9; i++) tick();
    uv_a = 1'b1; ui_a = 5'd0; uw_a = 2'd3; ud_a = 1'b0;
    #1;
    check_val("t5_busy_mid", 32'(busy_a), 32'h1);
    check_val("t5_victim_busy", 32'(victim_a), 32'h0);
    tick();
    uv_a = 1'b0;
    reset_pulse_a();
    wait_init_a("init2");
    lookup_a = 5'd0; #1;
    check_val("t5_set0", 32'(order_a), 32'hE4);
    lookup_a = 5'd5; #1;
    check_val("t5_set5_reinit", 32'(order_a), 32'hE4);

    // Test 6: random stream on the 8-way instance
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 8; k++) model[s][k] = k;
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    begin
      int n;
      n = 0;
      while (busy_b && n < 200) begin
        check_val("b_busy_zero", 32'(order_b), 32'h0);
        n++;
        tick();
      end
      check_val("b_init_len", n, 64);
    end
    for (int c = 0; c < 3000; c++) begin
      lookup_b = 6'($urandom_range(0, 63));
      uv_b     = ($urandom_range(0, 3) != 0);
      // Bias updates toward the looked-up set to exercise read-before-write.
      ui_b     = ($urandom_range(0, 3) == 0) ? lookup_b : 6'($urandom_range(0, 63));
      uw_b     = 3'($urandom_range(0, 7));
      ud_b     = ($urandom_range(0, 2) == 0);
      #1;
      check_val("b_victim", 32'(victim_b), 32'(model[lookup_b][7]));
      check_val("b_order", 32'(order_b), 32'(model_row(lookup_b)));
      if (c % 16 == 0) check_val("b_perm", 32'(way_mask(order_b)), 32'hFF);
      tick();
      if (uv_b) model_upd(int'(ui_b), int'(uw_b), ud_b);
    end
    uv_b = 1'b0;
    for (int s = 0; s < 64; s++) begin
      lookup_b = 6'(s);
      #1;
      check_val("b_final", 32'(order_b), 32'(model_row(s)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
